// File: rtl/multicycle_control.sv
// Multicycle control sequencer for the 2-bit-opcode core.
// One memory port and one ALU are time-shared across fetch, decode, execute,
// memory and writeback steps. Memory steps wait on mem_ready, and every
// completed instruction pulses retire and bumps a wrapping debug counter.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       Opcode,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] instr_count_r;

    // Zero only qualifies the PC load inside the datapath; the sequence ignores it.
    logic unused_zero_s;
    assign unused_zero_s = Zero;

    assign state       = state_r;
    assign instr_count = instr_count_r;

    // State sequencing and retired-instruction counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_FETCH;
            instr_count_r <= {CNT_W{1'b0}};
        end else begin
            if (retire) begin
                instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                instr_count_r <= instr_count_r;
            end
            case (state_r)
                S_FETCH:  state_r <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (Opcode)
                        2'd0:    state_r <= S_EXEC;
                        2'd1:    state_r <= S_MEMADR;
                        2'd2:    state_r <= S_MEMADR;
                        2'd3:    state_r <= S_BRANCH;
                        default: state_r <= S_FETCH;
                    endcase
                end
                S_MEMADR: begin
                    case (Opcode)
                        2'd1:    state_r <= S_MEMRD;
                        2'd2:    state_r <= S_MEMWR;
                        default: state_r <= S_FETCH;
                    endcase
                end
                S_MEMRD:  state_r <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWB:  state_r <= S_FETCH;
                S_MEMWR:  state_r <= mem_ready ? S_FETCH : S_MEMWR;
                S_EXEC:   state_r <= S_RWB;
                S_RWB:    state_r <= S_FETCH;
                S_BRANCH: state_r <= S_FETCH;
                default:  state_r <= S_FETCH;
            endcase
        end
    end

    // Control decode from the current state; reset silences every strobe at once.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 1'b0;
        retire      = 1'b0;
        if (rst) begin
            retire = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                    end else begin
                        IRWrite = 1'b0;
                        PCWrite = 1'b0;
                    end
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    retire   = mem_ready;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 1'b1;
                    retire      = 1'b1;
                end
                default: begin
                    retire = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (counter width 4 so the
// wrap case stays short).
module tb_multicycle_control;

    logic       clk, rst, Zero, mem_ready;
    logic [1:0] Opcode;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, PCSource, retire;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] instr_count, state;

    int tests    = 0;
    int failed   = 0;
    int ret_seen = 0;

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .retire(retire), .instr_count(instr_count), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [14:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    function automatic logic [14:0] cv(input logic pcw, pcwc, iord, mr, mw, irw,
                                       m2r, rd, rw, asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic pcs);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check one cycle's outputs (inputs already applied), then advance to just past the next edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [14:0] ct,
                       input logic ret, input logic [3:0] cnt);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".ctrl"},  32'(ctrl),  32'(ct));
        chk({tag, ".retire"}, 32'(retire), 32'(ret));
        chk({tag, ".count"}, 32'(instr_count), 32'(cnt));
        if (retire === 1'b1) ret_seen++;
        @(posedge clk);
        #1;
    endtask

    logic [14:0] c_fs, c_fr, c_dec, c_ma, c_mr, c_mwb, c_mw, c_ex, c_rwb, c_br;

    initial begin
        c_fs  = cv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        c_fr  = cv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        c_dec = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0);
        c_ma  = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0);
        c_mr  = cv(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        c_mwb = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        c_mw  = cv(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        c_ex  = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
        c_rwb = cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        c_br  = cv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1);

        // Reset held with mem_ready high: everything must stay quiet.
        rst = 1'b1; Opcode = 2'd0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("reset.state",  32'(state), 32'd0);
        chk("reset.ctrl",   32'(ctrl), 32'd0);
        chk("reset.retire", 32'(retire), 32'd0);
        chk("reset.count",  32'(instr_count), 32'd0);
        rst = 1'b0;

        // R-type, memory always ready.
        Opcode = 2'd0;
        cyc("r.fetch", 4'd0, c_fr, 1'b0, 4'd0);
        cyc("r.dec",   4'd1, c_dec, 1'b0, 4'd0);
        cyc("r.exec",  4'd6, c_ex, 1'b0, 4'd0);
        cyc("r.rwb",   4'd7, c_rwb, 1'b1, 4'd0);

        // Load with three not-ready cycles in MEMRD: 8 cycles total.
        Opcode = 2'd1;
        cyc("ld.fetch", 4'd0, c_fr, 1'b0, 4'd1);
        cyc("ld.dec",   4'd1, c_dec, 1'b0, 4'd1);
        cyc("ld.adr",   4'd2, c_ma, 1'b0, 4'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("ld.rdwait", 4'd3, c_mr, 1'b0, 4'd1);
        mem_ready = 1'b1;
        cyc("ld.rd",    4'd3, c_mr, 1'b0, 4'd1);
        cyc("ld.wb",    4'd4, c_mwb, 1'b1, 4'd1);

        // Store, then beq with Zero=1, then beq with Zero=0.
        Opcode = 2'd2;
        cyc("st.fetch", 4'd0, c_fr, 1'b0, 4'd2);
        cyc("st.dec",   4'd1, c_dec, 1'b0, 4'd2);
        cyc("st.adr",   4'd2, c_ma, 1'b0, 4'd2);
        cyc("st.wr",    4'd5, c_mw, 1'b1, 4'd2);
        Opcode = 2'd3; Zero = 1'b1;
        cyc("bz.fetch", 4'd0, c_fr, 1'b0, 4'd3);
        cyc("bz.dec",   4'd1, c_dec, 1'b0, 4'd3);
        cyc("bz.br",    4'd8, c_br, 1'b1, 4'd3);
        Zero = 1'b0;
        cyc("bn.fetch", 4'd0, c_fr, 1'b0, 4'd4);
        cyc("bn.dec",   4'd1, c_dec, 1'b0, 4'd4);
        cyc("bn.br",    4'd8, c_br, 1'b1, 4'd4);

        // Store with one not-ready cycle in MEMWR: no retire until ready.
        Opcode = 2'd2;
        cyc("st2.fetch", 4'd0, c_fr, 1'b0, 4'd5);
        cyc("st2.dec",   4'd1, c_dec, 1'b0, 4'd5);
        mem_ready = 1'b0;
        cyc("st2.adr",   4'd2, c_ma, 1'b0, 4'd5);
        cyc("st2.wait",  4'd5, c_mw, 1'b0, 4'd5);
        mem_ready = 1'b1;
        cyc("st2.wr",    4'd5, c_mw, 1'b1, 4'd5);

        // FETCH stall for five cycles, then an R-type.
        Opcode = 2'd0; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cyc("fs.stall", 4'd0, c_fs, 1'b0, 4'd6);
        mem_ready = 1'b1;
        cyc("fs.fetch", 4'd0, c_fr, 1'b0, 4'd6);
        cyc("fs.dec",   4'd1, c_dec, 1'b0, 4'd6);
        cyc("fs.exec",  4'd6, c_ex, 1'b0, 4'd6);
        cyc("fs.rwb",   4'd7, c_rwb, 1'b1, 4'd6);

        // Asynchronous reset in the middle of EXEC.
        cyc("rx.fetch", 4'd0, c_fr, 1'b0, 4'd7);
        cyc("rx.dec",   4'd1, c_dec, 1'b0, 4'd7);
        #1;
        chk("rx.exec.state", 32'(state), 32'd6);
        chk("rx.exec.ctrl",  32'(ctrl), 32'(c_ex));
        #2 rst = 1'b1;
        #1;
        chk("rx.state",  32'(state), 32'd0);
        chk("rx.ctrl",   32'(ctrl), 32'd0);
        chk("rx.retire", 32'(retire), 32'd0);
        chk("rx.count",  32'(instr_count), 32'd0);
        @(posedge clk); #1;
        chk("rx.hold.state", 32'(state), 32'd0);
        rst = 1'b0; mem_ready = 1'b0;
        cyc("rx.after", 4'd0, c_fs, 1'b0, 4'd0);

        // 17 back-to-back beq: the 4-bit counter wraps to 1.
        Opcode = 2'd3; mem_ready = 1'b1; ret_seen = 0;
        for (int k = 0; k < 17; k++) begin
            cyc("wr.fetch", 4'd0, c_fr, 1'b0, 4'(k));
            cyc("wr.dec",   4'd1, c_dec, 1'b0, 4'(k));
            cyc("wr.br",    4'd8, c_br, 1'b1, 4'(k));
        end
        #1;
        chk("wrap.count",   32'(instr_count), 32'd1);
        chk("wrap.retires", 32'(ret_seen), 32'd17);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle sequencer for the 2-bit-opcode core: opcode 0 = R-type, 1 = load, 2 = store, 3 = beq.
- It replaces single-cycle decoding with a state machine that time-shares one memory port and one ALU across fetch, decode, execute, memory and writeback steps.
- Memory accesses use a ready handshake, so variable-latency memory stalls the sequence.
- It also counts retired instructions for debug.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset.
- Opcode  in  2  instruction opcode from the instruction register; sampled in DECODE.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by Zero in the datapath.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  writeback data select: 1 = MDR.
- RegDst  out  1  destination select: 1 = rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 1, 10 = sign-ext imm, 11 = branch offset.
- ALUOp  out  2  ALU operation: 00 = add, 01 = sub, 10 = funct.
- PCSource  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- retire  out  1  one-cycle pulse when an instruction completes.
- instr_count  out  CNT_W  retired-instruction count.
- state  out  4  current state encoding, for debug.

Interface (already decided):
- One clock; reset is asynchronous and active-high.

Behaviour:
- Reset:
  - rst high forces state = FETCH (0) and instr_count = 0 immediately.
  - While rst is high, every control output and retire is forced to 0.
  - Reset mid-instruction abandons the instruction with no register or memory write.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8. Encodings 9–15 go to FETCH on the next edge and drive all outputs to 0.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1 (Mealy).
  - Next state is DECODE if mem_ready, else remain in FETCH.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by Opcode: 0 → EXEC, 1 or 2 → MEMADR, 3 → BRANCH.
- MEMADR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state is MEMRD if Opcode=1, MEMWR if Opcode=2.
- MEMRD:
  - Drives MemRead=1, IorD=1.
  - Remain in MEMRD until mem_ready, then go to MEMWB.
- MEMWB:
  - Drives RegWrite=1, MemtoReg=1, RegDst=0.
  - Retires; next state FETCH.
- MEMWR:
  - Drives MemWrite=1, IorD=1.
  - Remain in MEMWR until mem_ready, then retire and go to FETCH.
- EXEC:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state RWB.
- RWB:
  - Drives RegWrite=1, RegDst=1, MemtoReg=0.
  - Retires; next state FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1.
  - Retires regardless of Zero; next state FETCH.
- Unlisted outputs are 0 in each state.
- MemRead and MemWrite are never both 1.
- Latency with mem_ready always 1: R-type 4 cycles, load 5, store 4, beq 3. Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Retire and counter:
  - retire is combinational, high in the retiring cycle.
  - instr_count increments at the edge ending that cycle.
  - The count wraps modulo 2^CNT_W.
- Opcode is used only in DECODE and MEMADR. The instruction register must hold it stable from DECODE onward.

Test Plan:
- Reset: assert rst asynchronously mid-EXEC → state=0 and all outputs 0 before the next edge; after release, FETCH with MemRead=1.
- R-type, mem_ready tied to 1: state sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in RWB; retire=1 for one cycle; instr_count goes 0 → 1.
- Load with mem_ready low 3 cycles in MEMRD: MEMRD held 4 cycles with MemRead=1 and IorD=1; then MEMWB with RegWrite=1 and MemtoReg=1; total latency 8 cycles.
- Store followed by beq, Zero=1 then beq with Zero=0: store sequence 0,1,2,5,0; BRANCH drives PCWriteCond=1 and PCSource=1 in both beq cases; instr_count advances by 3.
- FETCH stall: mem_ready=0 for 5 cycles → IRWrite and PCWrite stay 0 throughout, then pulse exactly once when mem_ready rises.
- Counter wrap with CNT_W=4: 17 back-to-back beq instructions → instr_count=1; retire pulse count = 17.
